// File: rtl/module_display_7seg.sv
// -----------------------------------------------------------------------------
// module_display_7seg
//
// Display stage for the arithmetic result. A 16-bit unsigned value captured on
// a one-cycle strobe is converted to four BCD digits by an iterative
// double-dabble engine (one shift per clock). The result drives a 4-digit
// common-anode multiplexed 7-segment display. Values above 9999 show dashes on
// every digit. Leading zeros are blanked, and digit 0 always shows.
//
// Parameters:
//   REFRESH_CYCLES - clock cycles each digit stays lit (>= 1)
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous reset, active-high
//   dato       - unsigned value to display, sampled on dato_valid
//   dato_valid - one-cycle conversion request (ignored while busy)
//   busy       - high while a conversion is in progress
//   seg        - active-low segments {g,f,e,d,c,b,a}
//   an         - active-low one-hot digit enables, an[0] = least significant
// -----------------------------------------------------------------------------
module module_display_7seg #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dato,
    input  logic        dato_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int               CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    // Segment patterns, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t            state;
    logic [15:0]       bin_sr;     // binary half of the double-dabble shifter
    logic [15:0]       bcd_sr;     // BCD scratch, four nibbles
    logic [15:0]       dato_lat;   // unshifted copy for the overflow test
    logic [3:0]        iter;       // shift count, 0..15
    logic [15:0]       bcd_adj;    // scratch after the add-3 correction

    logic [15:0]       disp_bcd;   // display register: four BCD digits
    logic              disp_ovf;   // display register: overflow flag

    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        digit_idx;

    logic [3:0]        sel_digit;
    logic [15:0]       upper_digits;
    logic              blank;

    // ------------------------------------------------------------------------
    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    // ------------------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // ------------------------------------------------------------------------
    // Conversion FSM and display register.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the pre-edge values of its neighbours.
    // NOTE: the datapath registers are reset along with the control state;
    // an aborted conversion then leaves no stale partial result behind.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            dato_lat <= '0;
            iter     <= '0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dato_valid) begin
                        bin_sr   <= dato;
                        dato_lat <= dato;
                        bcd_sr   <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter             <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    // Above 9999 the fifth BCD digit is lost, so keep the old
                    // digits and flag overflow instead.
                    if (dato_lat > 16'd9999) begin
                        disp_ovf <= 1'b1;
                    end else begin
                        disp_bcd <= bcd_sr;
                        disp_ovf <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Free-running scan: each digit is lit for REFRESH_CYCLES clocks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Segment decode for the selected digit. A digit is blanked when it and
    // all more-significant digits are zero; digit 0 is never blanked.
    // ------------------------------------------------------------------------
    always_comb begin
        sel_digit    = disp_bcd[{digit_idx, 2'b00} +: 4];
        upper_digits = disp_bcd >> {digit_idx, 2'b00};
        blank        = (digit_idx != 2'd0) && (upper_digits == 16'd0);
        an           = ~(4'b0001 << digit_idx);

        if (disp_ovf) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            unique case (sel_digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule
